// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state encoding and counter sizing for the bit-serial adder
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One extra bit over the index width so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// serial_adder_ctrl_full_adder: the single 1-bit full-adder slice shared across all operand bits
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder with start/ready/done handshake
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN  = CW'((WIDTH > 1) ? WIDTH - 2 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             sum_bit, carry_out, last_bit, accept;
  logic [WIDTH-1:0] res_next;

  serial_adder_ctrl_full_adder u_full_adder (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (c_q),
    .s  (sum_bit),
    .co (carry_out)
  );

  assign last_bit = (cnt_q == LAST);
  assign accept   = (state_q == IDLE) && start;
  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB; the
  // concat-then-shift form also covers the WIDTH=1 case without a special slice.
  assign res_next = WIDTH'({sum_bit, res_q} >> 1);

  // State register: reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: IDLE waits for start, RUN walks WIDTH bits, DONE lasts one cycle.
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
              (state_q == RUN)  ? (last_bit ? DONE : RUN) :
                                  IDLE;
  end

  // Handshake outputs decode the state; results come straight from the holding flops.
  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    S     = s_q;
    Cout  = cout_q;
    V     = v_q;
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    opa_d  = opa_q;
    opb_d  = opb_q;
    res_d  = res_q;
    c_d    = c_q;
    cmsb_d = cmsb_q;
    cnt_d  = cnt_q;
    s_d    = s_q;
    cout_d = cout_q;
    v_d    = v_q;
    if (accept) begin
      opa_d  = A;
      opb_d  = B;
      c_d    = Cin;
      cmsb_d = Cin;
      cnt_d  = '0;
    end else if (state_q == RUN) begin
      opa_d  = opa_q >> 1;
      opb_d  = opb_q >> 1;
      res_d  = res_next;
      c_d    = carry_out;
      cnt_d  = cnt_q + CW'(1);
      cmsb_d = (WIDTH > 1 && cnt_q == PEN) ? carry_out : cmsb_q;
      if (last_bit) begin
        s_d    = res_next;
        cout_d = carry_out;
        v_d    = cmsb_q ^ carry_out;
      end
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      c_q    <= 1'b0;
      cmsb_q <= 1'b0;
      cnt_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      res_q  <= res_d;
      c_q    <= c_d;
      cmsb_q <= cmsb_d;
      cnt_q  <= cnt_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      v_q    <= v_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the bit-serial adder at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic       Cin = 1'b0;
  logic       ready, busy, done, Cout, V;
  logic [7:0] S;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
  logic ready1, busy1, done1, s1, cout1, v1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .ready(ready), .busy(busy), .done(done), .S(S), .Cout(Cout), .V(V)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(ci1),
    .ready(ready1), .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .V(v1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input logic ev);
    int lat = 0;
    wait_ready(tag);
    A = a; B = b; Cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_run_rbd"}, 32'({ready, busy, done}), 32'b010);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_S"}, 32'(S), 32'(es));
    check({tag, "_Cout"}, 32'(Cout), 32'(ec));
    check({tag, "_V"}, 32'(V), 32'(ev));
    check({tag, "_done_busy"}, 32'({done, busy}), 32'b10);
  endtask

  task automatic run_op1(input string tag, input logic a, input logic b, input logic ci,
                         input logic es, input logic ec, input logic ev);
    int lat = 0;
    int n = 0;
    while (!ready1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, 32'(ready1), 32'd1);
    a1 = a; b1 = b; ci1 = ci; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check({tag, "_busy"}, 32'(busy1), 32'd1);
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_S"}, 32'(s1), 32'(es));
    check({tag, "_Cout"}, 32'(cout1), 32'(ec));
    check({tag, "_V"}, 32'(v1), 32'(ev));
  endtask

  initial begin
    int nd, nb, ov, first, second, lat;
    #12;
    check("rst_rbd", 32'({ready, busy, done}), 32'b100);
    check("rst_S", 32'(S), 32'h0);
    check("rst_CV", 32'({Cout, V}), 32'b00);
    check("rst1_rbd", 32'({ready1, busy1, done1}), 32'b100);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("op_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("hold_rbd", 32'({ready, busy, done}), 32'b100);
    check("hold_S", 32'(S), 32'h7F);

    run_op("op_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("op_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("op_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_op("op_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // start held high: dones expected on edges 9, 19, 29 after the first IDLE edge
    wait_ready("cont");
    A = 8'h11; B = 8'h22; Cin = 1'b0; start = 1'b1;
    nd = 0; ov = 0; first = -1; second = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (done && busy) ov++;
    end
    start = 1'b0;
    check("cont_ndone", 32'(nd), 32'd3);
    check("cont_first", 32'(first), 32'd9);
    check("cont_period", 32'(second - first), 32'd10);
    check("cont_overlap", 32'(ov), 32'd0);
    check("cont_S", 32'(S), 32'h33);

    // operands and start disturbed mid-RUN
    wait_ready("mid");
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (3) begin
      @(posedge clk); #1;
      lat++;
    end
    A = 8'hFF; B = 8'hFF; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("mid_lat", 32'(lat), 32'd8);
    check("mid_S", 32'(S), 32'h46);
    check("mid_CV", 32'({Cout, V}), 32'b00);
    nd = 0; nb = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (busy) nb++;
    end
    check("mid_extra_done", 32'(nd), 32'd0);
    check("mid_extra_busy", 32'(nb), 32'd0);

    // reset at RUN bit 3
    wait_ready("abort");
    A = 8'h55; B = 8'h55; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rbd", 32'({ready, busy, done}), 32'b100);
    check("abort_S", 32'(S), 32'h0);
    check("abort_CV", 32'({Cout, V}), 32'b00);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    run_op("post_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    run_op1("w1_111", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run_op1("w1_100", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op1("w1_110", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
